// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared types, funct3 codes and legality check for load_store_unit
// Revision: 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    end
    return !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// load_store_unit_if : pipeline-side and memory-side bundles of the LSU
// Revision: 1.0
// ============================================================================
interface lsu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// lsu_lane_align : byte-lane steering for stores and load merge/extension
// Revision: 1.0
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] beat0_i,
  input  logic [23:0] beat1_i,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  size_mask;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [31:0] merged;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    // Upper half of the widened value is exactly what spills into beat 1.
    be_wide    = {4'b0000, size_mask} << off_i;
    wdata_wide = {32'd0, wdata_i} << {off_i, 3'b000};

    case (off_i)
      2'd0:    merged = beat0_i;
      2'd1:    merged = {beat1_i[7:0],  beat0_i[31:8]};
      2'd2:    merged = {beat1_i[15:0], beat0_i[31:16]};
      default: merged = {beat1_i[23:0], beat0_i[31:24]};
    endcase

    case (funct3_i)
      LB:      rdata_o = {{24{merged[7]}}, merged[7:0]};
      LH:      rdata_o = {{16{merged[15]}}, merged[15:0]};
      LW:      rdata_o = merged;
      LBU:     rdata_o = {24'd0, merged[7:0]};
      LHU:     rdata_o = {16'd0, merged[15:0]};
      default: rdata_o = 32'd0;
    endcase
  end

  assign be0_o    = be_wide[3:0];
  assign be1_o    = be_wide[7:4];
  assign wdata0_o = wdata_wide[31:0];
  assign wdata1_o = wdata_wide[63:32];

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : data-memory initiator with misaligned split and load extend
// Revision: 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  lsu_pipe_if.slave  pipe_if,
  lsu_mem_if.master  mem_if
);

  lsu_state_e            state_q, state_d;
  logic                  beat_q, beat_d;
  logic                  two_q, two_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  idle;
  logic [2:0]            al_funct3;
  logic [1:0]            al_off;
  logic [DATA_WIDTH-1:0] al_wdata, al_beat0, al_rdata, al_wdata0, al_wdata1;
  logic [23:0]           al_beat1;
  logic [3:0]            al_be0, al_be1;
  logic                  two_beat;
  logic [ADDR_WIDTH-1:0] base_addr;

  assign idle = (state_q == S_IDLE);

  // In IDLE the aligner sees the incoming request so beat 0 can launch at accept.
  assign al_funct3 = idle ? pipe_if.req_funct3     : funct3_q;
  assign al_off    = idle ? pipe_if.req_addr[1:0]  : addr_q[1:0];
  assign al_wdata  = idle ? pipe_if.req_wdata      : wdata_q;
  assign al_beat0  = beat_q ? beat0_q : mem_if.mem_rdata;
  assign al_beat1  = beat_q ? mem_if.mem_rdata[23:0] : 24'd0;

  assign two_beat  = ((al_funct3[1:0] == 2'b01) && (al_off == 2'b11)) ||
                     ((al_funct3[1:0] == 2'b10) && (al_off != 2'b00));
  assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_lane_align u_align (
    .funct3_i (al_funct3),
    .off_i    (al_off),
    .wdata_i  (al_wdata),
    .beat0_i  (al_beat0),
    .beat1_i  (al_beat1),
    .be0_o    (al_be0),
    .be1_o    (al_be1),
    .wdata0_o (al_wdata0),
    .wdata1_o (al_wdata1),
    .rdata_o  (al_rdata)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    two_d        = two_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat0_d      = beat0_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (pipe_if.req_valid) begin
          we_d     = pipe_if.req_we;
          funct3_d = pipe_if.req_funct3;
          addr_d   = pipe_if.req_addr;
          wdata_d  = pipe_if.req_wdata;
          beat_d   = 1'b0;
          beat0_d  = '0;
          two_d    = two_beat;
          if (!is_legal(pipe_if.req_we, pipe_if.req_funct3)) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = pipe_if.req_we;
            mem_addr_d  = {pipe_if.req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = al_be0;
            mem_wdata_d = pipe_if.req_we ? al_wdata0 : '0;
          end
        end
      end
      S_REQ: begin
        if (mem_if.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_if.mem_rvalid) begin
          if (two_q && !beat_q) begin
            beat0_d     = mem_if.mem_rdata;
            beat_d      = 1'b1;
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = base_addr + ADDR_WIDTH'(4);
            mem_be_d    = al_be1;
            mem_wdata_d = we_q ? al_wdata1 : '0;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = we_q ? '0 : al_rdata;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= 1'b0;
      two_q        <= 1'b0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat0_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      two_q        <= two_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat0_q      <= beat0_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign pipe_if.req_ready  = idle;
  assign pipe_if.resp_valid = resp_valid_q;
  assign pipe_if.resp_err   = resp_err_q;
  assign pipe_if.resp_rdata = resp_rdata_q;
  assign mem_if.mem_req     = mem_req_q;
  assign mem_if.mem_we      = mem_we_q;
  assign mem_if.mem_addr    = mem_addr_q;
  assign mem_if.mem_be      = mem_be_q;
  assign mem_if.mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : vector table + scoreboard bench with a word memory model
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_pipe_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) pipe_if ();
  lsu_mem_if  #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_if ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .pipe_if (pipe_if),
    .mem_if  (mem_if)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  beat_t       beats[$];
  exp_t        sb_q[$];
  logic [31:0] mem[16];
  int          gnt_stall = 0;
  int          rv_delay  = 0;
  bit          inject    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: grants after gnt_stall cycles, answers rv_delay cycles after grant.
  initial begin : mem_model
    logic        pend, holding;
    int          rv_cnt, stall_left;
    logic [31:0] rd_word;
    logic [3:0]  idx;
    beat_t       cur, hold;
    pend = 1'b0; holding = 1'b0; rv_cnt = 0; stall_left = 0; rd_word = '0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    foreach (mem[i]) mem[i] = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0; holding = 1'b0;
      end else begin
        if (pend) begin
          if (rv_cnt == 0) begin
            mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rd_word; pend = 1'b0;
          end else rv_cnt--;
        end else if (inject) begin
          mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hBAD0BAD0;
        end
        if (mem_if.mem_req) begin
          cur = '{mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata};
          if (holding) begin
            chk("hold_addr", cur.addr, hold.addr);
            chk("hold_be", 32'(cur.be), 32'(hold.be));
            chk("hold_we", 32'(cur.we), 32'(hold.we));
          end else begin
            stall_left = gnt_stall;
            hold = cur;
          end
          if (stall_left > 0) begin
            stall_left--;
            holding = 1'b1;
          end else begin
            holding = 1'b0;
            mem_if.mem_gnt = 1'b1;
            beats.push_back(cur);
            idx = cur.addr[5:2];
            if (cur.we)
              for (int b = 0; b < 4; b++)
                if (cur.be[b]) mem[idx][8*b +: 8] = cur.wdata[8*b +: 8];
            rd_word = mem[idx];
            pend = 1'b1;
            rv_cnt = rv_delay;
          end
        end
      end
    end
  end

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, output int lat);
    exp_t e;
    int   waited;
    bit   seen;
    beats.delete();
    waited = 0;
    @(negedge clk);
    while (!pipe_if.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("req_ready", 32'(pipe_if.req_ready), 32'd1);
    pipe_if.req_valid  = 1'b1;
    pipe_if.req_we     = we;
    pipe_if.req_funct3 = f3;
    pipe_if.req_addr   = addr;
    pipe_if.req_wdata  = wdata;
    sb_q.push_back('{exp_rdata, exp_err});
    @(posedge clk);
    lat  = 1;
    seen = 1'b0;
    while (!seen) begin
      @(negedge clk);
      pipe_if.req_valid = 1'b0;
      if (pipe_if.resp_valid) seen = 1'b1;
      else if (lat >= 200) break;
      else lat++;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got no resp_valid, want one within 200 cycles");
      lat = -1;
    end else begin
      chk("resp_rdata", pipe_if.resp_rdata, e.rdata);
      chk("resp_err", 32'(pipe_if.resp_err), 32'(e.err));
    end
  endtask

  function automatic vec_t V(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int nb, input logic [31:0] a0,
                             input logic [3:0] be0, input logic [31:0] wd0, input logic [31:0] a1,
                             input logic [3:0] be1, input logic [31:0] wd1,
                             input logic [31:0] rdata, input logic err, input int lat);
    vec_t v;
    v = '{we, f3, addr, wdata, nb, a0, be0, wd0, a1, be1, wd1, rdata, err, lat};
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[$];
    int          lat, seen_resp;
    logic [31:0] ea[2], ew[2];
    logic [3:0]  eb[2];

    pipe_if.req_valid = 1'b0; pipe_if.req_we = 1'b0; pipe_if.req_funct3 = 3'd0;
    pipe_if.req_addr = '0; pipe_if.req_wdata = '0;

    #12;
    chk("reset_ready", 32'(pipe_if.req_ready), 32'd1);
    chk("reset_ctl", 32'({mem_if.mem_req, mem_if.mem_we, pipe_if.resp_valid, pipe_if.resp_err}), 32'd0);
    chk("reset_addr", mem_if.mem_addr, 32'd0);
    chk("reset_be", 32'(mem_if.mem_be), 32'd0);
    chk("reset_wdata", mem_if.mem_wdata, 32'd0);
    chk("reset_rdata", pipe_if.resp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    //             we  f3      addr          wdata         nb a0            be0   wd0           a1    be1   wd1           rdata         err lat
    vecs.push_back(V(1, SW,    32'h10,       32'hDEADBEEF, 1, 32'h10,       4'hF, 32'hDEADBEEF, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(1, SW,    32'h10,       32'h80FF1234, 1, 32'h10,       4'hF, 32'h80FF1234, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(0, LB,    32'h13,       0,            1, 32'h10,       4'h8, 0,            0,    4'h0, 0,            32'hFFFFFF80, 0, 3));
    vecs.push_back(V(0, LBU,   32'h13,       0,            1, 32'h10,       4'h8, 0,            0,    4'h0, 0,            32'h00000080, 0, 3));
    vecs.push_back(V(0, LH,    32'h12,       0,            1, 32'h10,       4'hC, 0,            0,    4'h0, 0,            32'hFFFF80FF, 0, 3));
    vecs.push_back(V(0, LHU,   32'h12,       0,            1, 32'h10,       4'hC, 0,            0,    4'h0, 0,            32'h000080FF, 0, 3));
    vecs.push_back(V(0, LH,    32'h10,       0,            1, 32'h10,       4'h3, 0,            0,    4'h0, 0,            32'h00001234, 0, 3));
    vecs.push_back(V(1, SW,    32'h0C,       32'h44332211, 1, 32'h0C,       4'hF, 32'h44332211, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(1, SW,    32'h10,       32'h88776655, 1, 32'h10,       4'hF, 32'h88776655, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(0, LW,    32'h0E,       0,            2, 32'h0C,       4'hC, 0,            32'h10, 4'h3, 0,          32'h66554433, 0, 5));
    vecs.push_back(V(1, SH,    32'h07,       32'h0000ABCD, 2, 32'h04,       4'h8, 32'hCD000000, 32'h08, 4'h1, 32'h000000AB, 32'h0,      0, 5));
    vecs.push_back(V(0, LH,    32'h07,       0,            2, 32'h04,       4'h8, 0,            32'h08, 4'h1, 0,          32'hFFFFABCD, 0, 5));
    vecs.push_back(V(0, LHU,   32'h07,       0,            2, 32'h04,       4'h8, 0,            32'h08, 4'h1, 0,          32'h0000ABCD, 0, 5));
    vecs.push_back(V(1, SB,    32'h05,       32'h12345677, 1, 32'h04,       4'h2, 32'h34567700, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(0, LBU,   32'h05,       0,            1, 32'h04,       4'h2, 0,            0,    4'h0, 0,            32'h00000077, 0, 3));
    vecs.push_back(V(1, SW,    32'hFFFFFFFC, 32'hA1B2C3D4, 1, 32'hFFFFFFFC, 4'hF, 32'hA1B2C3D4, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(1, SW,    32'h00,       32'h01020304, 1, 32'h00,       4'hF, 32'h01020304, 0,    4'h0, 0,            32'h0,        0, 3));
    vecs.push_back(V(0, LW,    32'hFFFFFFFE, 0,            2, 32'hFFFFFFFC, 4'hC, 0,            32'h00, 4'h3, 0,          32'h0304A1B2, 0, 5));
    vecs.push_back(V(1, SW,    32'h21,       32'h11223344, 2, 32'h20,       4'hE, 32'h22334400, 32'h24, 4'h1, 32'h00000011, 32'h0,      0, 5));
    vecs.push_back(V(0, LW,    32'h21,       0,            2, 32'h20,       4'hE, 0,            32'h24, 4'h1, 0,          32'h11223344, 0, 5));
    vecs.push_back(V(0, LHU,   32'h22,       0,            1, 32'h20,       4'hC, 0,            0,    4'h0, 0,            32'h00002233, 0, 3));
    vecs.push_back(V(0, LB,    32'h21,       0,            1, 32'h20,       4'h2, 0,            0,    4'h0, 0,            32'h00000044, 0, 3));
    vecs.push_back(V(0, 3'b011, 32'h10,      0,            0, 0,            4'h0, 0,            0,    4'h0, 0,            32'h0,        1, 1));
    vecs.push_back(V(0, 3'b110, 32'h10,      0,            0, 0,            4'h0, 0,            0,    4'h0, 0,            32'h0,        1, 1));
    vecs.push_back(V(1, 3'b011, 32'h10,      32'hDEADBEEF, 0, 0,            4'h0, 0,            0,    4'h0, 0,            32'h0,        1, 1));
    vecs.push_back(V(1, 3'b100, 32'h10,      32'hDEADBEEF, 0, 0,            4'h0, 0,            0,    4'h0, 0,            32'h0,        1, 1));
    vecs.push_back(V(1, SW,    32'h0F,       32'hCAFEF00D, 2, 32'h0C,       4'h8, 32'h0D000000, 32'h10, 4'h7, 32'h00CAFEF0, 32'h0,      0, 5));
    vecs.push_back(V(0, LW,    32'h0F,       0,            2, 32'h0C,       4'h8, 0,            32'h10, 4'h7, 0,          32'hCAFEF00D, 0, 5));

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, lat);
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d.nbeats", i), 32'(beats.size()), 32'(vecs[i].nb));
      ea = '{vecs[i].a0, vecs[i].a1};
      eb = '{vecs[i].be0, vecs[i].be1};
      ew = '{vecs[i].wd0, vecs[i].wd1};
      for (int b = 0; b < 2; b++) begin
        if (b < vecs[i].nb && b < beats.size()) begin
          chk($sformatf("v%0d.addr%0d", i, b), beats[b].addr, ea[b]);
          chk($sformatf("v%0d.be%0d", i, b), 32'(beats[b].be), 32'(eb[b]));
          chk($sformatf("v%0d.we%0d", i, b), 32'(beats[b].we), 32'(vecs[i].we));
          if (vecs[i].we) chk($sformatf("v%0d.wdata%0d", i, b), beats[b].wdata, ew[b]);
        end
      end
    end

    // Grant stalled three cycles on an aligned word load.
    gnt_stall = 3;
    do_txn(0, LW, 32'h10, 0, 32'h88CAFEF0, 1'b0, lat);
    gnt_stall = 0;
    chk("stall.latency", 32'(lat), 32'd6);
    chk("stall.nbeats", 32'(beats.size()), 32'd1);
    if (beats.size() > 0) begin
      chk("stall.addr", beats[0].addr, 32'h10);
      chk("stall.be", 32'(beats[0].be), 32'hF);
    end

    // Reset while REQ is stalled: mem_req must drop asynchronously.
    gnt_stall = 5;
    @(negedge clk);
    pipe_if.req_valid = 1'b1; pipe_if.req_we = 1'b0; pipe_if.req_funct3 = LW; pipe_if.req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk); pipe_if.req_valid = 1'b0;
    #2 chk("rstreq.pre_req", 32'(mem_if.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq.mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rstreq.ready", 32'(pipe_if.req_ready), 32'd1);
    @(negedge clk); #2 rst = 1'b0;
    gnt_stall = 0;

    // Reset while WAIT, then a stray rvalid that must not complete anything.
    rv_delay = 4;
    @(negedge clk);
    pipe_if.req_valid = 1'b1; pipe_if.req_we = 1'b0; pipe_if.req_funct3 = LW; pipe_if.req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk); pipe_if.req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstwait.mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rstwait.ready", 32'(pipe_if.req_ready), 32'd1);
    chk("rstwait.resp", 32'(pipe_if.resp_valid), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    rv_delay = 0;
    @(negedge clk); #1 inject = 1'b1;
    @(negedge clk); #1 inject = 1'b0;
    seen_resp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pipe_if.resp_valid) seen_resp++;
    end
    chk("stray.resp_count", 32'(seen_resp), 32'd0);

    do_txn(0, LBU, 32'h13, 0, 32'h00000088, 1'b0, lat);
    chk("recover.latency", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory load/store interface. It accepts one load or store per transaction from the execute stage and issues word-aligned requests with byte enables to the data memory over a request/grant/response handshake. It splits accesses that cross a word boundary into two memory beats. For loads, it merges and sign- or zero-extends the returned data by funct3 before returning it to the pipeline.

## Interface
- DATA_WIDTH, 32, data and word width (the byte-lane logic is defined for 32 only)
- ADDR_WIDTH, 32, byte address width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  pipeline request valid
- req_ready  output  1  unit idle; request accepted when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data (low-aligned)
- resp_valid  output  1  one-cycle completion pulse; no backpressure
- resp_rdata  output  DATA_WIDTH  extended load data (0 for stores and errors)
- resp_err  output  1  illegal funct3, valid with resp_valid
- mem_req  output  1  memory request
- mem_gnt  input  1  memory accepts request this cycle
- mem_we  output  1  write beat
- mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_be  output  4  byte enables
- mem_wdata  output  DATA_WIDTH  lane-shifted store data
- mem_rvalid  input  1  beat complete (load data or store ack)
- mem_rdata  input  DATA_WIDTH  returned word

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP. A beat index (0/1) and a two-beat flag are latched at accept.
- IDLE: req_ready = 1. On accept, latch all request fields and off = addr[1:0], then go to REQ. If funct3 is illegal, go to RESP with the error flag set instead.
  - Illegal for loads: 011, 110, 111.
  - Illegal for stores: any funct3 other than 000, 001, 010.
- REQ: assert mem_req. Beat 0 uses addr & ~3; beat 1 uses (addr & ~3) + 4, wrapping modulo 2^ADDR_WIDTH. On mem_gnt, go to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata for the current beat. If this is the first beat of a two-beat access, go to REQ with beat 1. Otherwise go to RESP.
- RESP: pulse resp_valid for one cycle with the final data, then go to IDLE.
- A two-beat access is a halfword with off = 3, or a word with off ≠ 0.
- Store byte enables:
  - Byte: be = 0001 << off.
  - Half: be = 0011 << off, truncated to 4 bits.
  - Word: be = 1111 << off, truncated.
  - Beat 1 carries the spilled lanes: 1111 >> (4 − off), restricted to the size.
- Store data: beat 0 is wdata << 8·off; beat 1 is wdata >> 8·(4 − off).
- Load data: form {beat1, beat0} (beat1 = 0 for a single beat) and shift it right by 8·off.
  - lb and lh sign-extend from bit 7 and bit 15.
  - lbu and lhu zero-extend.
  - lw takes the low 32 bits.
- Loads also drive be for the accessed lanes, so the memory may ignore it.
- mem_rvalid outside WAIT is ignored.
- req_valid outside IDLE is ignored, because req_ready = 0.

## Timing
- Reset values: state IDLE (so req_ready = 1); mem_req, mem_we, resp_valid, resp_err = 0; mem_addr, mem_be, mem_wdata, resp_rdata = 0.
- Outputs mem_* and resp_* are registered. req_ready is decoded from state.
- mem_addr, mem_be, mem_wdata and mem_we are held stable while mem_req = 1 && mem_gnt = 0.
- mem_rvalid arrives at least one cycle after mem_gnt. Only one beat is outstanding at a time.
- Latency with a zero-wait memory (gnt the same cycle, rvalid one cycle later), accept at cycle T:
  - Single beat: mem_req at T+1, resp_valid at T+3.
  - Two beats: resp_valid at T+5.
  - Each stall cycle on gnt or rvalid adds one cycle.
- Illegal funct3: resp_valid = 1 and resp_err = 1 at T+1; no mem_req.
- Reset asserted in any state returns to IDLE immediately. The in-flight transaction is dropped, no resp_valid is produced, and any late rvalid is ignored.

## Structure
- Shared package lsu_pkg holds:
  - the state enum
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - load and store opcode constants
  - helper function is_legal(we, funct3)
- Sub-module lsu_lane_align is purely combinational. It computes beat-0 and beat-1 be and wdata from (funct3, off, wdata), and extracts and extends load data from (funct3, off, beat0, beat1).
- load_store_unit owns the FSM, the beat counter and all registers.

## Test plan
- sw addr 0x10, wdata 0xDEADBEEF -> one beat: mem_addr 0x10, be 1111, wdata 0xDEADBEEF, mem_we 1; resp_valid at T+3, resp_rdata 0.
- lb addr 0x13, mem[0x10] = 0x80FF1234 -> be 1000, resp_rdata 0xFFFFFF80. lbu at the same address -> 0x00000080.
- lw addr 0x0E, mem[0x0C] = 0x44332211, mem[0x10] = 0x88776655 -> beats to 0x0C (be 1100) then 0x10 (be 0011); resp_rdata 0x66554433 at T+5.
- sh addr 0x07, wdata 0x0000ABCD -> beat 0: addr 0x04, be 1000, wdata 0xCD000000. Beat 1: addr 0x08, be 0001, wdata 0x000000AB.
- mem_gnt held low 3 cycles on an aligned lw -> addr, be and we stable throughout; resp_valid at T+6. A load with funct3 011 -> no mem_req; resp_err = 1 at T+1.
- rst pulsed while in WAIT -> mem_req = 0 and req_ready = 1 immediately. A stray mem_rvalid after release produces no resp_valid.
